// File: rtl/ctrl_pkg.sv
// ============================================================================
// ctrl_pkg: opcode/funct encodings, ALU/immediate codes and state types
// Revision: 1.0
// ============================================================================
`default_nettype none

package ctrl_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [6:0] F7_ADD = 7'b0000000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    WRITEBACK = 3'd3,
    TRAP      = 3'd4
  } ctrl_state_t;

  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_ALU    = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4
  } instr_class_t;

endpackage

`default_nettype wire

// File: rtl/ctrl_decode.sv
// ============================================================================
// ctrl_decode: combinational IR decode into class, control fields, legal bit
// Revision: 1.0
// ============================================================================
`default_nettype none

module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic [6:0]   funct7,
  output instr_class_t cls,
  output logic [2:0]   alu_ctrl,
  output logic         alu_src,
  output logic [1:0]   imm_src,
  output logic         result_src,
  output logic         is_bne,
  output logic         legal
);

  always_comb begin
    cls        = CLS_NONE;
    alu_ctrl   = ALU_ADD;
    alu_src    = 1'b0;
    imm_src    = IMM_I;
    result_src = 1'b0;
    is_bne     = 1'b0;
    legal      = 1'b0;
    case (opcode)
      OP_IMM: if (funct3 == F3_ADD) begin
        cls     = CLS_ALU;
        alu_src = 1'b1;
        legal   = 1'b1;
      end
      OP_REG: if (funct3 == F3_ADD && funct7 == F7_ADD) begin
        cls   = CLS_ALU;
        legal = 1'b1;
      end
      OP_LOAD: if (funct3 == F3_LW) begin
        cls        = CLS_LOAD;
        alu_src    = 1'b1;
        result_src = 1'b1;
        legal      = 1'b1;
      end
      OP_STORE: if (funct3 == F3_SW) begin
        cls     = CLS_STORE;
        alu_src = 1'b1;
        imm_src = IMM_S;
        legal   = 1'b1;
      end
      OP_BRANCH: if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
        cls      = CLS_BRANCH;
        alu_ctrl = ALU_SUB;
        imm_src  = IMM_B;
        is_bne   = (funct3 == F3_BNE);
        legal    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl: FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the RV32I core.
// Optional retired-instruction counter: MULTICYCLE_CTRL_INSTR_COUNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ALU_CTRL_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     instr,
  input  logic                      eq,
  output logic                      ir_write,
  output logic [ALU_CTRL_WIDTH-1:0] alu_ctrl,
  output logic                      alu_src,
  output logic [1:0]                imm_src,
  output logic                      reg_write,
  output logic                      mem_write,
  output logic                      result_src,
  output logic                      pc_en,
  output logic                      pc_src,
  output logic                      illegal,
  output logic [31:0]               instr_count
);

  ctrl_state_t           state;
  logic [DATA_WIDTH-1:0] ir;
  logic                  illegal_q;

  instr_class_t dec_cls;
  logic [2:0]   dec_alu_ctrl;
  logic         dec_alu_src;
  logic [1:0]   dec_imm_src;
  logic         dec_result_src;
  logic         dec_is_bne;
  logic         dec_legal;

  // Register and immediate fields belong to the datapath.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir[24:15], ir[11:7]};

  ctrl_decode u_decode (
    .opcode     (ir[6:0]),
    .funct3     (ir[14:12]),
    .funct7     (ir[31:25]),
    .cls        (dec_cls),
    .alu_ctrl   (dec_alu_ctrl),
    .alu_src    (dec_alu_src),
    .imm_src    (dec_imm_src),
    .result_src (dec_result_src),
    .is_bne     (dec_is_bne),
    .legal      (dec_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      ir        <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          ir    <= instr;
          state <= DECODE;
        end
        DECODE: begin
          if (dec_legal) begin
            state <= EXECUTE;
          end else begin
            state     <= TRAP;
            illegal_q <= 1'b1;
          end
        end
        EXECUTE:   state <= (dec_cls == CLS_STORE || dec_cls == CLS_BRANCH) ? FETCH : WRITEBACK;
        WRITEBACK: state <= FETCH;
        TRAP:      state <= TRAP;
        default:   state <= FETCH;
      endcase
    end
  end

  // Outputs are decoded from state and IR; rst masks them so an aborted
  // instruction never produces a write or PC update.
  always_comb begin
    ir_write   = 1'b0;
    alu_ctrl   = '0;
    alu_src    = 1'b0;
    imm_src    = 2'b00;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    result_src = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: ir_write = 1'b1;
        EXECUTE: begin
          alu_ctrl = ALU_CTRL_WIDTH'(dec_alu_ctrl);
          alu_src  = dec_alu_src;
          imm_src  = dec_imm_src;
          if (dec_cls == CLS_BRANCH) begin
            pc_en  = 1'b1;
            pc_src = dec_is_bne ? ~eq : eq;
          end else if (dec_cls == CLS_STORE) begin
            mem_write = 1'b1;
            pc_en     = 1'b1;
          end
        end
        WRITEBACK: begin
          alu_ctrl   = ALU_CTRL_WIDTH'(dec_alu_ctrl);
          alu_src    = dec_alu_src;
          imm_src    = dec_imm_src;
          reg_write  = 1'b1;
          result_src = dec_result_src;
          pc_en      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign illegal = illegal_q & ~rst;

`ifdef MULTICYCLE_CTRL_INSTR_COUNT_EN
  logic [31:0] count_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (pc_en) begin
      count_q <= count_q + 32'd1;
    end
  end
  assign instr_count = count_q;
`else
  assign instr_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// tb_multicycle_ctrl: table-driven vectors plus trap/reset/counter sequences
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        eq = 1'b0;
  logic        ir_write, alu_src, reg_write, mem_write, result_src, pc_en, pc_src, illegal;
  logic [2:0]  alu_ctrl;
  logic [1:0]  imm_src;
  logic [31:0] instr_count;

  int tests = 0;
  int fails = 0;

  multicycle_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .eq          (eq),
    .ir_write    (ir_write),
    .alu_ctrl    (alu_ctrl),
    .alu_src     (alu_src),
    .imm_src     (imm_src),
    .reg_write   (reg_write),
    .mem_write   (mem_write),
    .result_src  (result_src),
    .pc_en       (pc_en),
    .pc_src      (pc_src),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        eq;
    logic        is_long;     // 4-cycle instruction with WRITEBACK
    logic [2:0]  alu_ctrl;
    logic        alu_src;
    logic [1:0]  imm_src;
    logic        mem_write;
    logic        pc_src;      // EXECUTE value for short instructions
    logic        result_src;  // WRITEBACK value for long instructions
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] enables();
    return {ir_write, reg_write, mem_write, pc_en};
  endfunction

  // Assumes DUT is in FETCH at the sample point; leaves it in FETCH.
  task automatic run_vec(input vec_t v);
    instr = v.instr;
    eq    = ~v.eq;
    check({v.name, " fetch enables"}, 32'(enables()), 32'b1000);
    step();
    instr = 32'hDEAD_BEEF;
    check({v.name, " decode enables"}, 32'(enables()), 32'b0000);
    eq = v.eq;
    #1;
    check({v.name, " decode pc_src eq-insensitive"}, 32'(pc_src), 32'd0);
    eq = ~v.eq;
    #1;
    check({v.name, " decode pc_src eq-insensitive 2"}, 32'(pc_src), 32'd0);
    eq = v.eq;
    step();
    check({v.name, " exec alu_ctrl"}, 32'(alu_ctrl), 32'(v.alu_ctrl));
    check({v.name, " exec alu_src"}, 32'(alu_src), 32'(v.alu_src));
    check({v.name, " exec imm_src"}, 32'(imm_src), 32'(v.imm_src));
    check({v.name, " exec reg/mem write"}, 32'({reg_write, mem_write}), 32'({1'b0, v.mem_write}));
    check({v.name, " exec pc_en"}, 32'(pc_en), 32'(!v.is_long));
    if (!v.is_long) check({v.name, " exec pc_src"}, 32'(pc_src), 32'(v.pc_src));
    if (v.is_long) begin
      eq = ~v.eq;
      step();
      check({v.name, " wb enables"}, 32'(enables()), 32'b0101);
      check({v.name, " wb pc_src"}, 32'(pc_src), 32'd0);
      check({v.name, " wb result_src"}, 32'(result_src), 32'(v.result_src));
      check({v.name, " wb alu held"}, 32'({alu_ctrl, alu_src, imm_src}), 32'({v.alu_ctrl, v.alu_src, v.imm_src}));
    end
    step();
    check({v.name, " back to fetch"}, 32'(enables()), 32'b1000);
  endtask

  initial begin
    int exp_cnt;
    //        name        instr          eq    long  alu    src   imm    mw    pcs   res
    vecs[0] = '{"addi",   32'h00500093, 1'b0, 1'b1, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"beq_t",  32'h00208463, 1'b1, 1'b0, 3'b001, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{"beq_nt", 32'h00208463, 1'b0, 1'b0, 3'b001, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{"bne_t",  32'hFE009EE3, 1'b0, 1'b0, 3'b001, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{"bne_nt", 32'hFE009EE3, 1'b1, 1'b0, 3'b001, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{"lw",     32'h0000A103, 1'b0, 1'b1, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{"sw",     32'h0020A223, 1'b1, 1'b0, 3'b000, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{"add",    32'h002081B3, 1'b1, 1'b1, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};

    // Reset state: all outputs low while rst is held.
    rst = 1'b1;
    step();
    step();
    check("reset outputs", 32'({ir_write, alu_ctrl, alu_src, imm_src, reg_write, mem_write,
                                result_src, pc_en, pc_src, illegal}), 32'd0);
    check("reset count", instr_count, 32'd0);
    rst = 1'b0;
    #1;
    check("post-reset fetch", 32'(enables()), 32'b1000);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Counter: three retired instructions after a fresh reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("count after reset", instr_count, 32'd0);
    run_vec(vecs[0]);
    run_vec(vecs[6]);
    run_vec(vecs[1]);
`ifdef MULTICYCLE_CTRL_INSTR_COUNT_EN
    exp_cnt = 3;
`else
    exp_cnt = 0;
`endif
    check("count after three", instr_count, 32'(exp_cnt));

    // Reset raised during WRITEBACK of an add suppresses the writeback.
    instr = 32'h002081B3;
    step();
    step();
    step();
    check("add wb reached", 32'(reg_write), 32'd1);
    rst = 1'b1;
    #1;
    check("rst in wb enables", 32'(enables()), 32'b0000);
    step();
    rst = 1'b0;
    #1;
    check("rst in wb -> fetch", 32'(enables()), 32'b1000);
    check("rst in wb count", instr_count, 32'd0);

    // Illegal opcode traps and holds until reset.
    instr = 32'h0000_0000;
    step();
    check("trap decode illegal", 32'(illegal), 32'd0);
    step();
    for (int i = 0; i < 10; i++) begin
      eq = i[0];
      check($sformatf("trap cycle %0d illegal", i), 32'(illegal), 32'd1);
      check($sformatf("trap cycle %0d enables", i), 32'(enables()), 32'b0000);
      step();
    end
    rst = 1'b1;
    #1;
    check("trap rst illegal", 32'(illegal), 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("trap cleared illegal", 32'(illegal), 32'd0);
    check("trap cleared fetch", 32'(enables()), 32'b1000);
    run_vec(vecs[7]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control unit for the RV32I lab core. It is the producer side of the ALU interface: it drives ALU control, operand select and writeback enables, and consumes the ALU `eq` flag to resolve branches. It latches each fetched instruction, then sequences FETCH/DECODE/EXECUTE/WRITEBACK so the datapath executes one instruction per 3–4 cycles.

Parameters:
- DATA_WIDTH, 32, instruction width; only 32 is supported.
- ALU_CTRL_WIDTH, 3, width of the ALU control code.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  DATA_WIDTH  instruction memory read data; valid during FETCH.
- eq  in  1  ALU equality flag; sampled in EXECUTE for branches.
- ir_write  out  1  datapath instruction-register load enable.
- alu_ctrl  out  ALU_CTRL_WIDTH  000=add, 001=sub.
- alu_src  out  1  0=rs2, 1=immediate.
- imm_src  out  2  00=I-type, 01=S-type, 10=B-type.
- reg_write  out  1  register file write enable.
- mem_write  out  1  data memory write enable.
- result_src  out  1  0=ALU result, 1=memory read data.
- pc_en  out  1  PC update strobe, exactly one cycle per instruction.
- pc_src  out  1  0=PC+4, 1=PC+branch offset.
- illegal  out  1  sticky flag: an unsupported opcode/funct was decoded.
- instr_count  out  32  retired-instruction counter (see Optional Feature).

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset, while rst is high at a clock edge:
  - state goes to FETCH; internal IR clears to 0; illegal=0; instr_count=0.
  - While rst is high, all outputs are forced to 0 (alu_ctrl=000, imm_src=00).
  - Reset asserted mid-instruction aborts it; no reg_write, mem_write or pc_en is issued.
- Supported instructions:
  - addi: opcode 0010011, funct3 000.
  - add: opcode 0110011, funct3 000, funct7 0.
  - lw: opcode 0000011, funct3 010.
  - sw: opcode 0100011, funct3 010.
  - beq/bne: opcode 1100011, funct3 000/001.
- States:
  - FETCH: ir_write=1; IR <= instr at the edge; go to DECODE.
  - DECODE: decode IR. Supported -> EXECUTE. Unsupported -> TRAP.
  - EXECUTE:
    - alu_ctrl = 001 for branch, else 000.
    - alu_src = 1 for addi/lw/sw, else 0.
    - imm_src set per type.
    - Branch: pc_en=1; pc_src = eq for beq, !eq for bne (combinational on eq, Mealy); then FETCH.
    - sw: mem_write=1, pc_en=1, pc_src=0; then FETCH.
    - add/addi/lw: go to WRITEBACK.
  - WRITEBACK: reg_write=1; result_src=1 for lw; pc_en=1, pc_src=0; ALU controls held from EXECUTE; then FETCH.
  - TRAP: illegal=1; all enables 0; stays in TRAP until rst.
- Latency:
  - add/addi/lw: 4 cycles.
  - beq/bne/sw: 3 cycles.
  - FETCH always follows the pc_en cycle.
- Invariants:
  - pc_en, reg_write and mem_write are never asserted outside their listed states.
  - reg_write and mem_write are never high in the same cycle.
- The `eq` input is ignored in every state except EXECUTE with a branch in IR.
- The register-file x0 guard is in the datapath; this block asserts reg_write even when rd=0.

Optional Feature:
- Macro: MULTICYCLE_CTRL_INSTR_COUNT_EN.
- Defined: instr_count increments by 1 on every cycle with pc_en=1. It wraps from 0xFFFFFFFF to 0 and clears on rst.
- Undefined: instr_count is tied to 0 and no counter flops are built. The port is present in both builds.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams: OP_IMM, OP_REG, OP_LOAD, OP_STORE, OP_BRANCH;
  - funct3 constants;
  - ALU_ADD / ALU_SUB codes;
  - IMM_I / IMM_S / IMM_B codes;
  - state enum ctrl_state_t: FETCH, DECODE, EXECUTE, WRITEBACK, TRAP.
- Sub-module ctrl_decode: purely combinational. It maps IR to an instruction class, the per-instruction control fields and a legal bit. The top level holds the FSM, the IR register, the pc_src mux and the counter.

Test Plan:
- Reset, then instr=0x00500093 (addi x1,x0,5) -> ir_write in cycle 0; cycle 2 alu_src=1, imm_src=00, alu_ctrl=000; cycle 3 reg_write=1, pc_en=1, pc_src=0; cycle 4 back in FETCH.
- instr=0x00208463 (beq x1,x2,8) with eq=1 in EXECUTE -> cycle 2 alu_ctrl=001, imm_src=10, pc_en=1, pc_src=1, reg_write=0. Repeat with eq=0 -> pc_src=0.
- instr=0xFE009EE3 (bne x1,x0,-4) with eq=0 -> pc_src=1. Toggle eq in other states -> no output change.
- instr=0x0000A103 (lw) then 0x0020A223 (sw) -> lw: cycle 3 reg_write=1, result_src=1. sw: cycle 2 mem_write=1, pc_en=1, no WRITEBACK.
- instr=0x00000000 -> TRAP from cycle 2; illegal=1 held, no enables for 10 cycles. Then rst=1 for 1 cycle -> illegal=0, FETCH.
- rst raised during WRITEBACK of an add -> no reg_write that cycle. With MULTICYCLE_CTRL_INSTR_COUNT_EN: instr_count=0 after reset and 3 after three completed instructions; without the macro it stays 0.
